leg_opclass_decoder: RTL and testbench
======================================

Name: leg_opclass_decoder

Overview:
Parametrised, registered successor to the LEG 2-bit opcode-class decoder. It extracts a configurable select field from each instruction word and emits a one-hot class vector through a one-entry output register with a valid/ready handshake. It also counts and flags instructions whose select field is zero (class 0, no functional unit). It sits between instruction fetch and the ALU/memory/branch enables of the LEG core.

Parameters:
INSTR_WIDTH, 8, instruction word width in bits.
SEL_LSB, 6, bit index of the select field LSB.
SEL_WIDTH, 2, select field width; NUM_CLASS = 2**SEL_WIDTH.
CNT_WIDTH, 8, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  instr is valid this cycle.
in_ready  output  1  decoder accepts instr this cycle.
instr  input  INSTR_WIDTH  instruction word.
out_valid  output  1  class_onehot is valid.
out_ready  input  1  consumer takes the output this cycle.
class_onehot  output  NUM_CLASS  one-hot class; bit k is set when sel==k.
class_id  output  SEL_WIDTH  binary select field of the held instruction.
illegal  output  1  held instruction is class 0 (qualified by out_valid).
err_sticky  output  1  set on any accepted class-0 instruction; cleared by err_clr.
err_cnt  output  CNT_WIDTH  count of accepted class-0 instructions, saturating.
err_clr  input  1  synchronous clear of err_sticky and err_cnt.

Behaviour:
- Select field: sel = instr[SEL_LSB+SEL_WIDTH-1 : SEL_LSB]. Elaboration fails (static check) if SEL_LSB+SEL_WIDTH > INSTR_WIDTH.
- Reset: out_valid=0, class_onehot=0, class_id=0, illegal=0, err_sticky=0, err_cnt=0. in_ready=1 in the first cycle after reset.
- in_ready = !out_valid || out_ready. This is combinational, with no input-to-output bubble.
- Accept: a transfer happens when in_valid && in_ready. On the next edge the register loads class_id=sel, class_onehot=1<<sel, illegal=(sel==0), and out_valid=1. Latency is 1 cycle.
- Output consumed without a new accept (out_valid && out_ready && !(in_valid && in_ready)): out_valid goes to 0, and class_onehot and illegal go to 0. This gives zero-when-invalid semantics, matching the switched outputs of the previous generation. class_id keeps its last value.
- Stall (out_valid && !out_ready): all output registers hold and in_ready=0. instr is ignored.
- Back-to-back: with out_ready held at 1, one instruction is accepted per cycle and out_valid stays at 1.
- Class 0 accepted: err_sticky<=1. err_cnt increments by 1 and saturates at 2**CNT_WIDTH-1, with no wrap. The event is counted at accept time, not at consume time.
- err_clr: clears err_sticky and err_cnt to 0 on that edge.
- err_clr in the same cycle as a class-0 accept: clear wins, so err_cnt=0 and err_sticky=0. That event is lost by design.
- Reset mid-stall: the held output is discarded and out_valid=0 on the next cycle. The dropped entry is not counted again.
- There are no X outputs after reset. class_onehot is either zero or exactly one-hot at all times.

Test Plan:
- Reset, then accept instr=0x40 with out_ready=1 -> next cycle out_valid=1, class_onehot=4'b0010, class_id=1, illegal=0. With no further input, out_valid=0 and class_onehot=0 the cycle after.
- Stream 0x80, 0xC0, 0x40 on consecutive cycles with out_ready=1 -> class_onehot=0100, 1000, 0010 on consecutive cycles, out_valid continuously 1, in_ready continuously 1.
- Accept 0x80, then hold out_ready=0 for 3 cycles while driving instr=0xC0 -> in_ready=0, class_onehot stays 0100. Raise out_ready -> 0xC0 is accepted and appears as 1000 one cycle later.
- Accept 300 instructions of 0x05 (class 0) -> illegal=1 on each, err_sticky=1, err_cnt=255 with no wrap. Pulse err_clr -> err_cnt=0, err_sticky=0.
- Pulse err_clr in the same cycle a 0x00 is accepted -> err_cnt=0, err_sticky=0, but the output shows illegal=1 and class_onehot=0001.
- Assert rst during a stall holding 0xC0 -> next cycle out_valid=0, class_onehot=0, err_cnt=0, in_ready=1. Re-run with parameters SEL_LSB=4, SEL_WIDTH=3: instr=0x50 -> class_onehot=8'b00100000, class_id=5.

Source files
------------

// File: rtl/leg_opclass_decoder.sv
// LEG opcode-class decoder: extracts a select field from each instruction and
// presents a one-hot class through a one-entry valid/ready output register.
module leg_opclass_decoder #(
  parameter int unsigned INSTR_WIDTH = 8,
  parameter int unsigned SEL_LSB     = 6,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH   = 8,
  localparam int unsigned NUM_CLASS  = 2 ** SEL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CLASS-1:0]   class_onehot,
  output logic [SEL_WIDTH-1:0]   class_id,
  output logic                   illegal,
  output logic                   err_sticky,
  output logic [CNT_WIDTH-1:0]   err_cnt,
  input  logic                   err_clr
);

  if (SEL_LSB + SEL_WIDTH > INSTR_WIDTH) begin : g_bad_sel
    $error("leg_opclass_decoder: select field exceeds instruction width");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [SEL_WIDTH-1:0] sel_c;
  logic                 accept_c;
  logic                 instr_unused_c;

  logic                 out_valid_q, out_valid_d;
  logic [NUM_CLASS-1:0] onehot_q, onehot_d;
  logic [SEL_WIDTH-1:0] class_id_q, class_id_d;
  logic                 illegal_q, illegal_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign sel_c          = instr[SEL_LSB +: SEL_WIDTH];
  assign instr_unused_c = ^instr;
  assign in_ready       = !out_valid_q || out_ready;
  assign accept_c       = in_valid && in_ready;

  // Output register and error-tracking next state.
  always_comb begin
    out_valid_d = out_valid_q;
    onehot_d    = onehot_q;
    class_id_d  = class_id_q;
    illegal_d   = illegal_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    if (accept_c) begin
      out_valid_d = 1'b1;
      onehot_d    = NUM_CLASS'(1) << sel_c;
      class_id_d  = sel_c;
      illegal_d   = (sel_c == '0);
    end else if (out_valid_q && out_ready) begin
      // Zero-when-invalid; class_id intentionally keeps its last value.
      out_valid_d = 1'b0;
      onehot_d    = '0;
      illegal_d   = 1'b0;
    end

    // Clear beats a coincident class-0 accept.
    if (err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (accept_c && (sel_c == '0)) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      onehot_q    <= '0;
      class_id_q  <= '0;
      illegal_q   <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      onehot_q    <= onehot_d;
      class_id_q  <= class_id_d;
      illegal_q   <= illegal_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign class_onehot = onehot_q;
  assign class_id     = class_id_q;
  assign illegal      = illegal_q;
  assign err_sticky   = sticky_q;
  assign err_cnt      = cnt_q;

endmodule

// File: tb/tb_leg_opclass_decoder.sv
// Bench for leg_opclass_decoder: default instance (sel=[7:6]) and a
// SEL_LSB=4/SEL_WIDTH=3 instance driven in lockstep against a behavioural model.
module tb_leg_opclass_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, out_ready, err_clr;
  logic [7:0] instr;

  logic       a_in_ready, a_out_valid, a_illegal, a_sticky;
  logic [3:0] a_onehot;
  logic [1:0] a_cid;
  logic [7:0] a_cnt;

  logic       b_in_ready, b_out_valid, b_illegal, b_sticky;
  logic [7:0] b_onehot;
  logic [2:0] b_cid;
  logic [7:0] b_cnt;

  leg_opclass_decoder u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .instr(instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .class_onehot(a_onehot),
    .class_id(a_cid), .illegal(a_illegal), .err_sticky(a_sticky), .err_cnt(a_cnt),
    .err_clr(err_clr)
  );

  leg_opclass_decoder #(.INSTR_WIDTH(8), .SEL_LSB(4), .SEL_WIDTH(3), .CNT_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .class_onehot(b_onehot),
    .class_id(b_cid), .illegal(b_illegal), .err_sticky(b_sticky), .err_cnt(b_cnt),
    .err_clr(err_clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state, one entry per instance.
  int lsb[2] = '{6, 4};
  int wid[2] = '{2, 3};
  bit m_valid[2];
  int m_cid[2];
  int m_hot[2];
  bit m_ill[2];
  bit m_sticky[2];
  int m_cnt[2];

  function automatic int sel_of(int d, logic [7:0] w);
    return (int'(w) >> lsb[d]) & ((1 << wid[d]) - 1);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_outputs(input int d);
    if (d == 0) begin
      chk("out_valid", d, 32'(a_out_valid), 32'(m_valid[d]));
      chk("onehot",    d, 32'(a_onehot),    32'(m_hot[d]));
      chk("class_id",  d, 32'(a_cid),       32'(m_cid[d]));
      chk("illegal",   d, 32'(a_illegal),   32'(m_ill[d]));
      chk("sticky",    d, 32'(a_sticky),    32'(m_sticky[d]));
      chk("err_cnt",   d, 32'(a_cnt),       32'(m_cnt[d]));
    end else begin
      chk("out_valid", d, 32'(b_out_valid), 32'(m_valid[d]));
      chk("onehot",    d, 32'(b_onehot),    32'(m_hot[d]));
      chk("class_id",  d, 32'(b_cid),       32'(m_cid[d]));
      chk("illegal",   d, 32'(b_illegal),   32'(m_ill[d]));
      chk("sticky",    d, 32'(b_sticky),    32'(m_sticky[d]));
      chk("err_cnt",   d, 32'(b_cnt),       32'(m_cnt[d]));
    end
  endtask

  // One clock of stimulus: drive, check ready, clock, update model, check outputs.
  task automatic step(input bit r, input bit iv, input logic [7:0] ins, input bit ordy, input bit clr);
    bit acc;
    int s;
    @(negedge clk);
    rst = r; in_valid = iv; instr = ins; out_ready = ordy; err_clr = clr;
    #1;
    chk("in_ready", 0, 32'(a_in_ready), 32'(!m_valid[0] || ordy));
    chk("in_ready", 1, 32'(b_in_ready), 32'(!m_valid[1] || ordy));
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      s   = sel_of(d, ins);
      acc = iv && (!m_valid[d] || ordy);
      if (r) begin
        m_valid[d] = 0; m_hot[d] = 0; m_cid[d] = 0; m_ill[d] = 0;
        m_sticky[d] = 0; m_cnt[d] = 0;
      end else begin
        if (acc) begin
          m_valid[d] = 1; m_cid[d] = s; m_hot[d] = 1 << s; m_ill[d] = (s == 0);
        end else if (m_valid[d] && ordy) begin
          m_valid[d] = 0; m_hot[d] = 0; m_ill[d] = 0;
        end
        if (clr) begin
          m_sticky[d] = 0; m_cnt[d] = 0;
        end else if (acc && s == 0) begin
          m_sticky[d] = 1;
          m_cnt[d] = (m_cnt[d] < 255) ? m_cnt[d] + 1 : 255;
        end
      end
    end
    #1;
    chk_outputs(0);
    chk_outputs(1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0; err_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_cid[d] = 0; m_hot[d] = 0; m_ill[d] = 0; m_sticky[d] = 0; m_cnt[d] = 0;
    end

    // Reset state
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);

    // Single accept then drain
    step(0, 1, 8'h40, 1, 0);
    chk("plan_onehot_0x40", 0, 32'(a_onehot), 32'h2);
    step(0, 0, 8'h00, 1, 0);

    // Back-to-back stream
    step(0, 1, 8'h80, 1, 0);
    step(0, 1, 8'hC0, 1, 0);
    step(0, 1, 8'h40, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    // Stall with a pending instruction, then release
    step(0, 1, 8'h80, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hC0, 0, 0);
    chk("plan_stall_hold", 0, 32'(a_onehot), 32'h4);
    step(0, 1, 8'hC0, 1, 0);
    chk("plan_release", 0, 32'(a_onehot), 32'h8);
    step(0, 0, 8'h00, 1, 0);

    // Saturating class-0 counter, then clear
    for (int i = 0; i < 300; i++) step(0, 1, 8'h05, 1, 0);
    chk("plan_saturate", 0, 32'(a_cnt), 32'd255);
    step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 1, 0);

    // Clear coincident with a class-0 accept
    step(0, 1, 8'h00, 1, 0);
    step(0, 1, 8'h00, 1, 1);
    chk("plan_clr_wins", 0, 32'(a_cnt), 32'd0);
    step(0, 0, 8'h00, 1, 0);

    // Reset during a stall
    step(0, 1, 8'hC0, 1, 0);
    step(0, 1, 8'h40, 0, 0);
    step(1, 1, 8'h40, 0, 0);
    step(0, 0, 8'h00, 0, 0);

    // Wider select field instance: 0x50 -> class 5
    step(0, 1, 8'h50, 1, 0);
    chk("plan_wide_onehot", 1, 32'(b_onehot), 32'h20);
    step(0, 0, 8'h00, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
